instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 8-bit factorial processor. It steps each instruction through fetch, decode, execute and memory-access states, and drives the datapath strobes (ULAOp, EscPC, EscMEM, LerMEM, RegFonte, EscReg) cycle by cycle. It also handles shared-memory wait states and multiplier latency. It sits between the instruction register / shared memory and the datapath, and replaces single-cycle decode.

---
 rtl/instr_sequencer.sv | 175 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the 8-bit factorial processor; strobes are combinational from state.
// SEQ_MUL_HS_EN: mule waits on mul_done instead of the internal MUL_LAT down-counter.
module instr_sequencer #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       gt_zero,
    input  logic       mem_ready,
`ifdef SEQ_MUL_HS_EN
    input  logic       mul_done,
`endif
    output logic [1:0] ULAOp,
    output logic       EscPC,
    output logic       PCSrc,
    output logic       EscIR,
    output logic       AddrSel,
    output logic       LerMEM,
    output logic       EscMEM,
    output logic       RegFonte,
    output logic       EscReg,
    output logic       busy,
    output logic       halted,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADDO = 3'b000;
    localparam logic [2:0] OP_SUBO = 3'b001;
    localparam logic [2:0] OP_MULE = 3'b010;
    localparam logic [2:0] OP_GZ   = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       mul_fire;

    logic [1:0] ula_op;
    logic       esc_pc, pc_src, esc_ir, addr_sel, ler_mem, esc_mem, reg_fonte, esc_reg;

`ifdef SEQ_MUL_HS_EN
    assign mul_fire = mul_done;
`else
    logic [3:0] mcnt_q, mcnt_d;

    // Loaded on every DECODE exit so it is primed whenever EXEC is entered.
    always_comb begin
        mcnt_d = mcnt_q;
        if (state_q == S_DECODE) begin
            mcnt_d = 4'(MUL_LAT - 1);
        end else if (state_q == S_EXEC && mcnt_q != 4'd0) begin
            mcnt_d = mcnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt_q <= 4'd0;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign mul_fire = (mcnt_q == 4'd0);
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ula_op    = 2'b00;
        esc_pc    = 1'b0;
        pc_src    = 1'b0;
        esc_ir    = 1'b0;
        addr_sel  = 1'b0;
        ler_mem   = 1'b0;
        esc_mem   = 1'b0;
        reg_fonte = 1'b0;
        esc_reg   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ler_mem = 1'b1;
                if (mem_ready) begin
                    esc_ir  = 1'b1;
                    esc_pc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                count_d = count_q + 8'd1;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_NOP:       state_d = S_FETCH;
                    3'b111:       state_d = S_HALT;
                    default:      state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_ADDO: esc_reg = 1'b1;
                    OP_SUBO: begin
                        ula_op  = 2'b01;
                        esc_reg = 1'b1;
                    end
                    OP_MULE: begin
                        ula_op = 2'b10;
                        if (mul_fire) esc_reg = 1'b1;
                        else          state_d = S_EXEC;
                    end
                    OP_GZ: begin
                        ula_op = 2'b11;
                        esc_pc = gt_zero;
                        pc_src = gt_zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (mem_ready) state_d = S_FETCH;
                case (opcode)
                    OP_LW: begin
                        ler_mem   = 1'b1;
                        reg_fonte = 1'b1;
                        esc_reg   = mem_ready;
                    end
                    OP_SW:   esc_mem = 1'b1;
                    default: state_d = S_FETCH;
                endcase
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Every output is held low while reset is asserted, independent of the state register.
    assign ULAOp       = reset ? 2'b00 : ula_op;
    assign EscPC       = ~reset & esc_pc;
    assign PCSrc       = ~reset & pc_src;
    assign EscIR       = ~reset & esc_ir;
    assign AddrSel     = ~reset & addr_sel;
    assign LerMEM      = ~reset & ler_mem;
    assign EscMEM      = ~reset & esc_mem;
    assign RegFonte    = ~reset & reg_fonte;
    assign EscReg      = ~reset & esc_reg;
    assign busy        = ~reset & (state_q != S_IDLE) & (state_q != S_HALT);
    assign halted      = ~reset & (state_q == S_HALT);
    assign instr_count = reset ? 8'd0 : count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-scenario tasks with hand-computed strobe vectors.
// Vector layout: {ULAOp[1:0], EscPC, PCSrc, EscIR, AddrSel, LerMEM, EscMEM, RegFonte, EscReg, busy, halted}.
module tb_instr_sequencer;

    localparam int MUL_LAT = 4;

    logic       clk = 1'b0;
    logic       reset, start, gt_zero, mem_ready, mul_done;
    logic [2:0] opcode;
    logic [1:0] ULAOp;
    logic       EscPC, PCSrc, EscIR, AddrSel, LerMEM, EscMEM, RegFonte, EscReg, busy, halted;
    logic [7:0] instr_count;
    logic [11:0] outs;

    int checks = 0;
    int fails  = 0;

    localparam logic [11:0] V_IDLE   = 12'h000;
    localparam logic [11:0] V_FETCH  = 12'h2A2;
    localparam logic [11:0] V_FWAIT  = 12'h022;
    localparam logic [11:0] V_DECODE = 12'h002;
    localparam logic [11:0] V_ADDO   = 12'h006;
    localparam logic [11:0] V_SUBO   = 12'h406;
    localparam logic [11:0] V_MULW   = 12'h802;
    localparam logic [11:0] V_MULD   = 12'h806;
    localparam logic [11:0] V_GZT    = 12'hF02;
    localparam logic [11:0] V_GZF    = 12'hC02;
    localparam logic [11:0] V_LWW    = 12'h06A;
    localparam logic [11:0] V_LWD    = 12'h06E;
    localparam logic [11:0] V_SW     = 12'h052;
    localparam logic [11:0] V_HALT   = 12'h001;

    always #5 clk = ~clk;

    instr_sequencer #(.MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .gt_zero     (gt_zero),
        .mem_ready   (mem_ready),
`ifdef SEQ_MUL_HS_EN
        .mul_done    (mul_done),
`endif
        .ULAOp       (ULAOp),
        .EscPC       (EscPC),
        .PCSrc       (PCSrc),
        .EscIR       (EscIR),
        .AddrSel     (AddrSel),
        .LerMEM      (LerMEM),
        .EscMEM      (EscMEM),
        .RegFonte    (RegFonte),
        .EscReg      (EscReg),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    assign outs = {ULAOp, EscPC, PCSrc, EscIR, AddrSel, LerMEM, EscMEM, RegFonte, EscReg, busy, halted};

    // Advance one cycle: inputs change just after the rising edge, sampling on the falling edge.
    task automatic step(input logic s, input logic mr, input logic gz, input logic md);
        @(posedge clk);
        #1;
        start     = s;
        mem_ready = mr;
        gt_zero   = gz;
        mul_done  = md;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; gt_zero = 1'b0; mul_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b1; mem_ready = 1'b1; gt_zero = 1'b1; mul_done = 1'b1; opcode = 3'b000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (outs !== V_IDLE || instr_count !== 8'd0) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: outs=%h cnt=%0d, want outs=%h cnt=0", i, outs, instr_count, V_IDLE);
            end
        end
        #1 reset = 1'b0; start = 1'b0; mem_ready = 1'b0; gt_zero = 1'b0; mul_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (outs !== V_IDLE || instr_count !== 8'd0) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: outs=%h cnt=%0d, want outs=%h cnt=0", i, outs, instr_count, V_IDLE);
            end
        end
    endtask

    task automatic test_alu();
        logic [11:0] exp [4];
        for (int op = 0; op < 2; op++) begin
            do_reset();
            opcode = 3'(op);
            start  = 1'b1;
            exp = '{V_FETCH, V_DECODE, (op == 1) ? V_SUBO : V_ADDO, V_FETCH};
            for (int c = 1; c <= 4; c++) begin
                step(1'b0, 1'b1, 1'b0, 1'b0);
                checks++;
                if (outs !== exp[c-1]) begin
                    fails++;
                    $display("FAIL alu op%0d cyc%0d: outs=%h want %h", op, c, outs, exp[c-1]);
                end
                if (c >= 3) begin
                    checks++;
                    if (instr_count !== 8'd1) begin
                        fails++;
                        $display("FAIL alu_count op%0d cyc%0d: cnt=%0d want 1", op, c, instr_count);
                    end
                end
            end
        end
    endtask

    task automatic test_gz();
        for (int g = 0; g < 2; g++) begin
            do_reset();
            opcode = 3'b011;
            start  = 1'b1;
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, g[0], 1'b0);
            checks++;
            if (outs !== ((g == 1) ? V_GZT : V_GZF)) begin
                fails++;
                $display("FAIL gz gt%0d: outs=%h want %h", g, outs, (g == 1) ? V_GZT : V_GZF);
            end
            step(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (outs !== V_FETCH) begin
                fails++;
                $display("FAIL gz_next gt%0d: outs=%h want %h", g, outs, V_FETCH);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [11:0] exp [6];
        logic        mr  [6];
        // lw: two wait cycles in MEM, completion on the third
        do_reset();
        opcode = 3'b100;
        start  = 1'b1;
        exp = '{V_FETCH, V_DECODE, V_LWW, V_LWW, V_LWD, V_FETCH};
        mr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, mr[c-1], 1'b0, 1'b0);
            checks++;
            if (outs !== exp[c-1]) begin
                fails++;
                $display("FAIL lw cyc%0d: outs=%h want %h", c, outs, exp[c-1]);
            end
        end
        // sw: one fetch wait, mem_ready low in DECODE is ignored, one MEM wait
        do_reset();
        opcode = 3'b101;
        start  = 1'b1;
        exp = '{V_FWAIT, V_FETCH, V_DECODE, V_SW, V_SW, V_FWAIT};
        mr  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 1; c <= 6; c++) begin
            step(1'b1, mr[c-1], 1'b0, 1'b0);
            checks++;
            if (outs !== exp[c-1]) begin
                fails++;
                $display("FAIL sw cyc%0d: outs=%h want %h", c, outs, exp[c-1]);
            end
        end
    endtask

    task automatic test_mule();
        int last;
        logic [11:0] want;
        do_reset();
        opcode = 3'b010;
        start  = 1'b1;
`ifdef SEQ_MUL_HS_EN
        last = 8;
`else
        last = 2 + MUL_LAT;
`endif
        for (int c = 1; c <= last + 1; c++) begin
            step(1'b1, 1'b1, 1'b0, (c == 8) ? 1'b1 : 1'b0);
            if (c == 1)           want = V_FETCH;
            else if (c == 2)      want = V_DECODE;
            else if (c < last)    want = V_MULW;
            else if (c == last)   want = V_MULD;
            else                  want = V_FETCH;
            checks++;
            if (outs !== want) begin
                fails++;
                $display("FAIL mule cyc%0d: outs=%h want %h", c, outs, want);
            end
        end
    endtask

    task automatic test_halt_wrap();
        do_reset();
        opcode = 3'b110;
        start  = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (outs !== V_FETCH || instr_count !== 8'(n - 1)) begin
                fails++;
                $display("FAIL nop_fetch n%0d: outs=%h cnt=%0d want outs=%h cnt=%0d", n, outs, instr_count, V_FETCH, n - 1);
            end
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        opcode = 3'b111;
        checks++;
        if (outs !== V_FETCH || instr_count !== 8'd0) begin
            fails++;
            $display("FAIL wrap: outs=%h cnt=%0d want outs=%h cnt=0", outs, instr_count, V_FETCH);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== V_DECODE) begin
            fails++;
            $display("FAIL halt_decode: outs=%h want %h", outs, V_DECODE);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            checks++;
            if (outs !== V_HALT || instr_count !== 8'd1) begin
                fails++;
                $display("FAIL halt cyc%0d: outs=%h cnt=%0d want outs=%h cnt=1", i, outs, instr_count, V_HALT);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== V_IDLE || instr_count !== 8'd0) begin
            fails++;
            $display("FAIL halt_reset_force: outs=%h cnt=%0d want outs=0 cnt=0", outs, instr_count);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== V_IDLE || instr_count !== 8'd0) begin
            fails++;
            $display("FAIL halt_reset_idle: outs=%h cnt=%0d want outs=0 cnt=0", outs, instr_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 3'b000;
        gt_zero = 1'b0; mem_ready = 1'b0; mul_done = 1'b0;
        test_reset();
        test_alu();
        test_gz();
        test_mem_wait();
        test_mule();
        test_halt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
